// File: rtl/jtag_scan_master.sv
// Host-side JTAG scan engine: walks the target TAP through one IR or DR scan per
// request, bit-banging TCK/TMS/TDI and capturing TDO into a MAX_LEN-wide result.
module jtag_scan_master #(
  parameter int MAX_LEN = 64,
  parameter int CLK_DIV = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic                         req_ir_i,
  input  logic [$clog2(MAX_LEN+1)-1:0] req_len_i,
  input  logic [MAX_LEN-1:0]           req_data_i,
  input  logic                         tlr_req_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [MAX_LEN-1:0]           rsp_data_o,
  output logic                         tck_o,
  output logic                         tms_o,
  output logic                         tdi_o,
  input  logic                         tdo_i,
  output logic                         trst_no
);
  localparam int LW = $clog2(MAX_LEN+1);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int XW = (LW > 3) ? LW : 3;
  localparam int CW = (CLK_DIV > 1) ? $clog2(2*CLK_DIV) : 1;

  typedef enum logic [2:0] {INIT, IDLE, TLR, HDR, SHIFT, TAIL, RESP} state_t;

  state_t             state, state_n;
  logic [CW-1:0]      cnt;
  logic [XW-1:0]      idx, last_q, last_c;
  logic               ir_q, tck_q, trst_q;
  logic [MAX_LEN-1:0] data_q, rsp_q;
  logic [LW-1:0]      len_c;
  logic               run, rise, slot_end;

  // Slot timer only runs while a TMS sequence is in flight; INIT waits for TRST release.
  assign run      = trst_q && (state != IDLE) && (state != RESP);
  assign rise     = run && (cnt == CW'(CLK_DIV-1));
  assign slot_end = run && (cnt == CW'(2*CLK_DIV-1));

  assign tck_o      = tck_q;
  assign trst_no    = trst_q;
  assign rsp_data_o = rsp_q;

  always_comb begin
    if (req_len_i == '0)                 len_c = LW'(1);
    else if (req_len_i > LW'(MAX_LEN))   len_c = LW'(MAX_LEN);
    else                                 len_c = req_len_i;
  end

  // TMS/TDI are a pure function of (state, slot index), so each slot's values
  // appear on the same edge that starts the slot.
  always_comb begin
    state_n     = state;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    tms_o       = 1'b0;
    tdi_o       = 1'b0;
    last_c      = '0;
    case (state)
      INIT, TLR: begin
        last_c = XW'(5);
        tms_o  = (idx != XW'(5));
        if (slot_end && idx == last_c) state_n = IDLE;
      end
      IDLE: begin
        req_ready_o = !tlr_req_i;
        if (tlr_req_i)        state_n = TLR;
        else if (req_valid_i) state_n = HDR;
      end
      HDR: begin
        last_c = ir_q ? XW'(3) : XW'(2);
        tms_o  = ir_q ? (idx < XW'(2)) : (idx == '0);
        if (slot_end && idx == last_c) state_n = SHIFT;
      end
      SHIFT: begin
        last_c = last_q;
        tms_o  = (idx == last_q);
        tdi_o  = data_q[idx[IW-1:0]];
        if (slot_end && idx == last_c) state_n = TAIL;
      end
      TAIL: begin
        last_c = XW'(1);
        tms_o  = (idx == '0);
        if (slot_end && idx == last_c) state_n = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_n = IDLE;
      end
      default: state_n = INIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= INIT;
      cnt    <= '0;
      idx    <= '0;
      last_q <= '0;
      ir_q   <= 1'b0;
      tck_q  <= 1'b0;
      trst_q <= 1'b0;
      data_q <= '0;
      rsp_q  <= '0;
    end else begin
      trst_q <= 1'b1;
      state  <= state_n;
      if (!run || slot_end) cnt <= '0;
      else                  cnt <= cnt + CW'(1);
      if (rise)          tck_q <= 1'b1;
      else if (slot_end) tck_q <= 1'b0;
      if (state_n != state) idx <= '0;
      else if (slot_end)    idx <= idx + XW'(1);
      if (state == IDLE && req_valid_i && req_ready_o) begin
        ir_q   <= req_ir_i;
        last_q <= XW'(len_c) - XW'(1);
        data_q <= req_data_i;
        rsp_q  <= '0;
      end
      if (rise && state == SHIFT) rsp_q[idx[IW-1:0]] <= tdo_i;
    end
  end
endmodule

// File: tb/tb_jtag_scan_master.sv
// Directed bench for jtag_scan_master with a behavioural 1149.1 TAP target
// (IDCODE 32'h10000db3, 5-bit IR, BYPASS = 5'h1F).
module tb_jtag_scan_master;
  localparam int MAX_LEN = 64;
  localparam int LW = $clog2(MAX_LEN+1);
  localparam logic [31:0] IDCODE = 32'h10000db3;
  localparam int TLR_S = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5,
                 PADR = 6, EX2DR = 7, UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11,
                 EX1IR = 12, PAIR = 13, EX2IR = 14, UPIR = 15;

  logic clk = 1'b0, rst_ni = 1'b0;
  logic req_valid = 1'b0, req_ir = 1'b0, tlr_req = 1'b0, rsp_ready = 1'b0;
  logic [LW-1:0] req_len = '0;
  logic [MAX_LEN-1:0] req_data = '0;
  logic req_ready, rsp_valid, tck, tms, tdi, tdo, trst_n;
  logic [MAX_LEN-1:0] rsp_data;
  logic tdo_tie = 1'b0;

  int checks = 0, errors = 0;
  int rises = 0, r0, cyc, n;
  logic [15:0] tms_log = '0;
  bit to, held, seen_valid;

  jtag_scan_master #(.MAX_LEN(MAX_LEN), .CLK_DIV(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_ir_i(req_ir), .req_len_i(req_len), .req_data_i(req_data), .tlr_req_i(tlr_req),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .tck_o(tck), .tms_o(tms), .tdi_o(tdi), .tdo_i(tdo), .trst_no(trst_n));

  always #5 clk = ~clk;

  always @(posedge tck) begin
    rises   <= rises + 1;
    tms_log <= {tms_log[14:0], tms};
  end

  // Behavioural TAP target
  int tap_st = TLR_S;
  logic [4:0] ir = 5'h01, ir_sr = '0;
  logic [31:0] dr_sr = '0;
  logic bp = 1'b0, tap_tdo = 1'b0;
  assign tdo = tdo_tie ? 1'b1 : tap_tdo;

  function automatic int tap_next(input int s, input logic m);
    case (s)
      TLR_S: return m ? TLR_S : RTI;
      RTI:   return m ? SELDR : RTI;
      SELDR: return m ? SELIR : CAPDR;
      CAPDR, SHDR: return m ? EX1DR : SHDR;
      EX1DR: return m ? UPDR : PADR;
      PADR:  return m ? EX2DR : PADR;
      EX2DR: return m ? UPDR : SHDR;
      UPDR, UPIR: return m ? SELDR : RTI;
      SELIR: return m ? TLR_S : CAPIR;
      CAPIR, SHIR: return m ? EX1IR : SHIR;
      EX1IR: return m ? UPIR : PAIR;
      PAIR:  return m ? EX2IR : PAIR;
      EX2IR: return m ? UPIR : SHIR;
      default: return TLR_S;
    endcase
  endfunction

  always @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tap_st <= TLR_S;
      ir     <= 5'h01;
    end else begin
      case (tap_st)
        TLR_S: ir <= 5'h01;
        CAPDR: begin dr_sr <= IDCODE; bp <= 1'b0; end
        SHDR:  if (ir == 5'h1F) bp <= tdi; else dr_sr <= {tdi, dr_sr[31:1]};
        CAPIR: ir_sr <= 5'h01;
        SHIR:  ir_sr <= {tdi, ir_sr[4:1]};
        UPIR:  ir <= ir_sr;
        default: ;
      endcase
      tap_st <= tap_next(tap_st, tms);
    end
  end

  always @(negedge tck) begin
    if (tap_st == SHDR)      tap_tdo <= (ir == 5'h1F) ? bp : dr_sr[0];
    else if (tap_st == SHIR) tap_tdo <= ir_sr[0];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic ir_i, input int len, input logic [63:0] data, output bit t);
    int k = 0;
    @(negedge clk);
    req_ir = ir_i; req_len = LW'(len); req_data = data; req_valid = 1'b1;
    while (!req_ready && k < 1000) begin @(negedge clk); k++; end
    t = !req_ready;
    @(posedge clk); #1;
    req_valid = 1'b0;
    r0 = rises;
  endtask

  task automatic wait_rsp(output bit t);
    int k = 0;
    while (!rsp_valid && k < 2000) begin @(negedge clk); k++; end
    t = !rsp_valid;
  endtask

  task automatic consume();
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
  endtask

  task automatic wait_init(output int c, output bit sv);
    c = 0; sv = 0;
    while (!req_ready && c < 200) begin
      @(posedge clk); #1; c++;
      if (rsp_valid) sv = 1;
    end
  endtask

  initial begin
    #12;
    chk("rst_tck", tck, 0);
    chk("rst_tms", tms, 1);
    chk("rst_tdi", tdi, 0);
    chk("rst_trst", trst_n, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);

    @(negedge clk); rst_ni = 1'b1;
    @(posedge clk); #1;
    chk("trst_after_1", trst_n, 1);
    cyc = 1;
    while (!req_ready && cyc < 200) begin @(posedge clk); #1; cyc++; end
    chk("init_ready_cycle", cyc, 49);
    chk("init_rises", rises, 6);
    chk("init_tms_seq", tms_log[5:0], 6'b111110);
    chk("init_tap_rti", tap_st, RTI);

    issue(1'b0, 32, 64'h0, to); chk("dr32_accept_to", to, 0);
    wait_rsp(to); chk("dr32_rsp_to", to, 0);
    chk("dr32_idcode", rsp_data, 64'h10000db3);
    chk("dr32_rises", rises - r0, 37);
    consume();
    chk("dr32_valid_clear", rsp_valid, 0);

    issue(1'b1, 5, 64'h1F, to); chk("ir5_accept_to", to, 0);
    wait_rsp(to); chk("ir5_rsp_to", to, 0);
    chk("ir5_capture", rsp_data, 64'h01);
    chk("ir5_rises", rises - r0, 11);
    chk("ir5_tms_seq", tms_log[10:0], 11'b11000000110);
    consume();

    issue(1'b0, 8, 64'hA5, to); chk("byp8_accept_to", to, 0);
    wait_rsp(to); chk("byp8_rsp_to", to, 0);
    chk("byp8_data", rsp_data, 64'h4A);
    chk("byp8_rises", rises - r0, 13);
    consume();

    tdo_tie = 1'b1;
    issue(1'b0, 0, 64'h0, to); chk("len0_accept_to", to, 0);
    wait_rsp(to); chk("len0_rsp_to", to, 0);
    chk("len0_data", rsp_data, 64'h1);
    chk("len0_rises", rises - r0, 6);
    consume();
    issue(1'b0, 100, 64'h0, to); chk("len100_accept_to", to, 0);
    wait_rsp(to); chk("len100_rsp_to", to, 0);
    chk("len100_data", rsp_data, {64{1'b1}});
    chk("len100_rises", rises - r0, 69);
    consume();
    tdo_tie = 1'b0;

    // Response back-pressure with a competing request held valid
    issue(1'b0, 8, 64'h3C, to); chk("hold_accept_to", to, 0);
    wait_rsp(to); chk("hold_rsp_to", to, 0);
    req_ir = 1'b0; req_len = LW'(4); req_data = 64'hF; req_valid = 1'b1;
    held = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); @(negedge clk);
      if (!(rsp_valid === 1'b1 && rsp_data === 64'h78 && req_ready === 1'b0)) held = 0;
    end
    chk("hold_stable", held, 1);
    chk("hold_data", rsp_data, 64'h78);
    consume();
    chk("hold_released_valid", rsp_valid, 0);
    chk("hold_ready_after", req_ready, 1);
    @(posedge clk); #1; req_valid = 1'b0; r0 = rises;
    wait_rsp(to); chk("pend_rsp_to", to, 0);
    chk("pend_data", rsp_data, 64'hE);
    chk("pend_rises", rises - r0, 9);
    consume();

    // TLR request wins over a simultaneous scan request
    @(negedge clk);
    req_ir = 1'b0; req_len = LW'(32); req_data = '0; req_valid = 1'b1; tlr_req = 1'b1;
    #1;
    chk("tlr_ready_low", req_ready, 0);
    @(posedge clk); #1; tlr_req = 1'b0; r0 = rises;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    chk("tlr_ready_to", req_ready, 1);
    chk("tlr_rises", rises - r0, 6);
    chk("tlr_tms_seq", tms_log[5:0], 6'b111110);
    chk("tlr_tap_rti", tap_st, RTI);
    @(posedge clk); #1; req_valid = 1'b0; r0 = rises;
    wait_rsp(to); chk("tlr_rsp_to", to, 0);
    chk("tlr_idcode", rsp_data, 64'h10000db3);
    chk("tlr_scan_rises", rises - r0, 37);
    consume();

    // Asynchronous reset in the middle of SHIFT
    issue(1'b0, 32, 64'h0, to); chk("mid_accept_to", to, 0);
    repeat (40) @(posedge clk);
    #3; rst_ni = 1'b0; #1;
    chk("mid_tck", tck, 0);
    chk("mid_tms", tms, 1);
    chk("mid_trst", trst_n, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    @(negedge clk); rst_ni = 1'b1; r0 = rises;
    wait_init(cyc, seen_valid);
    chk("reinit_cycle", cyc, 49);
    chk("reinit_no_rsp", seen_valid, 0);
    chk("reinit_rises", rises - r0, 6);
    chk("reinit_tms_seq", tms_log[5:0], 6'b111110);
    issue(1'b0, 32, 64'h0, to); chk("post_accept_to", to, 0);
    wait_rsp(to); chk("post_rsp_to", to, 0);
    chk("post_idcode", rsp_data, 64'h10000db3);
    consume();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/jtag_scan_master.md
Name: jtag_scan_master

Overview:
- Host-side JTAG driver: generates TCK/TMS/TDI/TRSTn, samples TDO and walks the IEEE 1149.1 TAP state machine of an attached target.
- Performs one IR or DR scan per request, of length 1..MAX_LEN bits, and returns the captured TDO bits.
- Drives our own jtag_tap_top from on-chip test logic, e.g. for configuration-register and debug-module access in SoC self-test and FPGA bring-up.

Parameters:
- MAX_LEN, 64, maximum scan length in bits; sets the data-bus width.
- CLK_DIV, 4, TCK half-period in clk_i cycles; must be ≥1.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  async active-low reset
- req_valid_i  in  1  scan request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_ir_i  in  1  1 = IR scan, 0 = DR scan
- req_len_i  in  $clog2(MAX_LEN+1)  scan length in bits
- req_data_i  in  MAX_LEN  TDI bits, LSB shifted first
- tlr_req_i  in  1  pulse: force Test-Logic-Reset then return to Run-Test/Idle
- rsp_valid_o  out  1  scan result valid
- rsp_ready_i  in  1  result consumed when valid&ready
- rsp_data_o  out  MAX_LEN  captured TDO, bit i = i-th sampled bit, unused MSBs 0
- tck_o  out  1  JTAG clock
- tms_o  out  1  JTAG mode select
- tdi_o  out  1  JTAG data to target
- tdo_i  in  1  JTAG data from target
- trst_no  out  1  JTAG reset to target, active low

Behaviour:
- Reset values: tck_o=0, tms_o=1, tdi_o=0, trst_no=0, req_ready_o=0, rsp_valid_o=0, rsp_data_o=0.
- trst_no goes to 1 on the first clk_i edge after rst_ni deasserts.
- TCK period (one "bit slot"), 2*CLK_DIV clk_i cycles:
  - At slot start, tck_o=0 and tms_o/tdi_o update.
  - After CLK_DIV cycles, tck_o rises and tdo_i is sampled on that same clk_i edge.
  - After a further CLK_DIV cycles, tck_o falls and the slot ends.
  - tck_o idles low between operations.
- FSM states: INIT, IDLE, TLR, HDR, SHIFT, TAIL, RESP.
- INIT: entered from reset. Runs 6 slots with TMS=1,1,1,1,1,0, then goes to IDLE (TAP now in Run-Test/Idle).
- IDLE:
  - req_ready_o=1 only in IDLE with rsp_valid_o=0.
  - tlr_req_i=1 goes to TLR and takes priority over a simultaneous req_valid_i; req_ready_o is forced 0 that cycle.
  - A valid&ready handshake latches ir, len and data, and goes to HDR.
- TLR: same 6-slot sequence as INIT, then back to IDLE. No response is produced.
- HDR (TDI=0):
  - DR scan: TMS=1,0,0 (SelDR, Capture, Shift).
  - IR scan: TMS=1,1,0,0 (SelDR, SelIR, Capture, Shift).
- SHIFT:
  - n slots; slot k drives TDI=data[k] and samples TDO into bit k.
  - TMS=0 except on the last slot, where TMS=1 (Shift to Exit1).
- TAIL: TMS=1,0 (Update, Run-Test/Idle), TDI=0, then goes to RESP.
- Total slots per scan: DR n+5, IR n+6.
- Length rules: req_len_i=0 is treated as 1; req_len_i>MAX_LEN is clamped to MAX_LEN.
- RESP:
  - rsp_valid_o=1 on the cycle after the last TAIL slot ends; rsp_data_o is stable while valid.
  - rsp_valid_o clears on valid&ready, and the FSM returns to IDLE the same edge.
  - rsp_ready_i held high gives a one-cycle valid pulse.
- tlr_req_i outside IDLE is ignored (not queued).
- Async rst_ni mid-scan: all outputs go to their reset values immediately and the INIT sequence reruns. The partial response is discarded.
- Shift-register width is MAX_LEN; bits at index ≥n in rsp_data_o are 0.

Test Plan:
- Reset, CLK_DIV=4 → trst_no=1 after 1 cycle; 6 TCK periods of 8 cycles each with TMS=1,1,1,1,1,0 sampled at TCK rise; req_ready_o=1 at cycle 49 after reset release.
- Bench jtag_tap_top (IDCODE 32'h10000db3) after INIT; DR scan len=32, data=0 → rsp_data_o[31:0]=32'h10000db3; 37 TCK rises observed.
- IR scan len=5, data=5'h1F (BYPASS) then DR scan len=8, data=8'hA5 → second rsp_data_o=8'h4A (bypass delays by one bit, first captured bit 0); IR scan uses 11 TCK periods.
- TDO tied 1, DR scan len=0 → 1 bit shifted, rsp_data_o=64'h1; len=100 → clamped to 64, rsp_data_o all ones.
- rsp_ready_i=0 for 20 cycles after rsp_valid_o → rsp_valid_o and data held, req_ready_o=0, new req_valid_i ignored; first accepted only after handshake.
- tlr_req_i and req_valid_i in the same IDLE cycle → TLR TMS sequence first, req_ready_o=0 that cycle; rst_ni pulsed mid-SHIFT → tck_o=0, tms_o=1, trst_no=0 immediately, no rsp_valid_o, INIT reruns.
